binary_window_filter: RTL and testbench

BINARY_WINDOW_FILTER -- requirements
Module: binary_window_filter

---
 rtl/binary_window_filter.sv | 177 +++++++++++++++++
 tb/tb_binary_window_filter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/binary_window_filter.sv
// Streaming 3x3 binary morphology filter (majority / erode / dilate / pass-through)
// over a raster-order 1-bit image, with an end-of-frame flush so every pixel gets an output.
module binary_window_filter #(
  parameter int IMG_W = 320,
  parameter int IMG_H = 480
) (
  input  logic       guass_clk,
  input  logic       rst,
  input  logic       CMOS_VSYNC,
  input  logic [1:0] mode,
  input  logic [3:0] thr,
  input  logic       data_in,
  input  logic       data_valid,
  output logic       in_ready,
  output logic       data_me,
  output logic       out_valid,
  output logic       frame_done
);

  localparam int NPIX = IMG_W * IMG_H;
  localparam int PW   = $clog2(NPIX + IMG_W + 1) + 1;
  localparam int CW   = $clog2(IMG_W);
  localparam int RW   = $clog2(IMG_H);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t        r_state;
  logic [PW-1:0] r_p;
  logic [CW-1:0] r_ccol;
  logic [CW-1:0] r_ptr;
  logic [RW-1:0] r_crow;
  logic [1:0]    r_mode;
  logic [3:0]    r_thr;
  logic          r_b1, r_b2, r_m1, r_m2, r_t1, r_t2;
  logic          r_rd1, r_rd2;
  logic          r_lb1 [IMG_W];
  logic          r_lb2 [IMG_W];

  logic          w_accept;
  logic          w_adv;
  logic          w_s;
  logic          w_eval;
  logic          w_last;
  logic          w_clear;
  logic [CW-1:0] w_ptr_next;
  logic [2:0]    w_row_ok;
  logic [2:0]    w_col_ok;
  logic [8:0]    w_tap;
  logic [8:0]    w_tap_m;
  logic [3:0]    w_sum;
  logic          w_res;

  assign in_ready = (r_state == IDLE) || (r_state == RUN);
  assign w_accept = data_valid && in_ready && !CMOS_VSYNC;
  assign w_adv    = (w_accept || (r_state == FLUSH)) && !CMOS_VSYNC;
  assign w_s      = w_accept && data_in;
  assign w_eval   = w_adv && (r_p >= PW'(IMG_W + 1));
  assign w_last   = (r_crow == RW'(IMG_H - 1)) && (r_ccol == CW'(IMG_W - 1));
  assign w_clear  = rst || CMOS_VSYNC || (r_state == DONE);

  // Read address runs one step ahead so the registered RAM output is ready on the next advance.
  always_comb begin
    w_ptr_next = r_ptr;
    if (w_clear) begin
      w_ptr_next = '0;
    end else if (w_adv) begin
      w_ptr_next = (r_ptr == CW'(IMG_W - 1)) ? '0 : r_ptr + CW'(1);
    end
  end

  always_ff @(posedge guass_clk) begin
    if (w_adv) begin
      r_lb1[r_ptr] <= w_s;
      r_lb2[r_ptr] <= r_rd1;
    end
    r_rd1 <= r_lb1[w_ptr_next];
    r_rd2 <= r_lb2[w_ptr_next];
  end

  // Tap index = row*3 + col, row 0 is the line above the centre; the newest bit is bottom-right.
  assign w_tap = {w_s, r_b1, r_b2, r_rd1, r_m1, r_m2, r_rd2, r_t1, r_t2};

  assign w_row_ok = {r_crow != RW'(IMG_H - 1), 1'b1, r_crow != '0};
  assign w_col_ok = {r_ccol != CW'(IMG_W - 1), 1'b1, r_ccol != '0};

  for (genvar gi = 0; gi < 9; gi++) begin : g_mask
    assign w_tap_m[gi] = w_tap[gi] & w_row_ok[gi / 3] & w_col_ok[gi % 3];
  end

  always_comb begin
    w_sum = '0;
    for (int i = 0; i < 9; i++) begin
      w_sum = w_sum + {3'b000, w_tap_m[i]};
    end
  end

  always_comb begin
    w_res = 1'b0;
    case (r_mode)
      2'd0: w_res = (w_sum > r_thr);
      2'd1: w_res = (w_sum == 4'd9);
      2'd2: w_res = (w_sum != 4'd0);
      default: w_res = w_tap_m[4];
    endcase
  end

  always_ff @(posedge guass_clk) begin
    r_ptr <= w_ptr_next;
  end

  always_ff @(posedge guass_clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_p        <= '0;
      r_ccol     <= '0;
      r_crow     <= '0;
      r_mode     <= 2'd0;
      r_thr      <= 4'd0;
      {r_b1, r_b2, r_m1, r_m2, r_t1, r_t2} <= '0;
      data_me    <= 1'b0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else if (CMOS_VSYNC) begin
      r_state    <= IDLE;
      r_p        <= '0;
      r_ccol     <= '0;
      r_crow     <= '0;
      {r_b1, r_b2, r_m1, r_m2, r_t1, r_t2} <= '0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      out_valid  <= w_eval;
      frame_done <= w_eval && w_last;
      if (w_eval) begin
        data_me <= w_res;
        if (r_ccol == CW'(IMG_W - 1)) begin
          r_ccol <= '0;
          r_crow <= r_crow + RW'(1);
        end else begin
          r_ccol <= r_ccol + CW'(1);
        end
      end
      if (w_adv) begin
        r_p  <= r_p + PW'(1);
        r_b1 <= w_s;
        r_b2 <= r_b1;
        r_m1 <= r_rd1;
        r_m2 <= r_m1;
        r_t1 <= r_rd2;
        r_t2 <= r_t1;
      end
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state <= RUN;
            r_mode  <= mode;
            r_thr   <= thr;
          end
        end
        RUN: begin
          if (w_accept && (r_p == PW'(NPIX - 1))) r_state <= FLUSH;
        end
        FLUSH: begin
          if (r_p == PW'(NPIX + IMG_W)) r_state <= DONE;
        end
        default: begin
          r_state <= IDLE;
          r_p     <= '0;
          r_ccol  <= '0;
          r_crow  <= '0;
          {r_b1, r_b2, r_m1, r_m2, r_t1, r_t2} <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_binary_window_filter.sv
// Scoreboard bench for binary_window_filter on an 8x4 image: the driver queues
// expected pixels from a 2-D neighbourhood model, a negedge monitor checks outputs.
module tb_binary_window_filter;

  localparam int W = 8;
  localparam int H = 4;
  localparam int N = W * H;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       vs = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [3:0] thr = 4'd0;
  logic       din = 1'b0;
  logic       dv = 1'b0;
  logic       in_ready, data_me, out_valid, frame_done;

  typedef struct packed {logic d; logic last;} exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int n_out = 0;
  int fd_count = 0;
  int frames = 0;

  always #5 clk = ~clk;

  binary_window_filter #(.IMG_W(W), .IMG_H(H)) dut (
    .guass_clk (clk),
    .rst       (rst),
    .CMOS_VSYNC(vs),
    .mode      (mode),
    .thr       (thr),
    .data_in   (din),
    .data_valid(dv),
    .in_ready  (in_ready),
    .data_me   (data_me),
    .out_valid (out_valid),
    .frame_done(frame_done)
  );

  task automatic check_int(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  function automatic logic ref_out(input logic [N-1:0] img, input int r, input int c,
                                   input logic [1:0] m, input logic [3:0] t);
    int s = 0;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        if (r + dr >= 0 && r + dr < H && c + dc >= 0 && c + dc < W)
          s += int'(img[(r + dr) * W + (c + dc)]);
      end
    end
    case (m)
      2'd0: return s > int'(t);
      2'd1: return s == 9;
      2'd2: return s != 0;
      default: return img[r * W + c];
    endcase
  endfunction

  // Monitor: one line per output transaction.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid) begin
        n_out++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got data_me=%0b, required no output", data_me);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          $display("out %0d data_me=%0b exp=%0b frame_done=%0b exp=%0b",
                   n_out, data_me, e.d, frame_done, e.last);
          check_int("data_me", int'(data_me), int'(e.d));
          check_int("frame_done", int'(frame_done), int'(e.last));
        end
      end else if (frame_done) begin
        check_int("frame_done_without_valid", 1, 0);
      end
      if (frame_done) fd_count++;
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check_int("wait_in_ready_timeout", int'(in_ready), 1);
  endtask

  task automatic send_frame(input logic [N-1:0] img, input logic [1:0] m,
                            input logic [3:0] t0, input logic [3:0] t1,
                            input bit gaps, input int npix);
    int lo;
    for (int k = 0; k < N; k++) begin
      if (npix == N || k < npix - (W + 1)) begin
        exp_t e;
        e.d = ref_out(img, k / W, k % W, m, t0);
        e.last = (npix == N) && (k == N - 1);
        exp_q.push_back(e);
      end
    end
    wait_ready();
    mode = m;
    thr = t0;
    for (int i = 0; i < npix; i++) begin
      if (gaps) begin
        int ng = int'($urandom_range(0, 2));
        for (int g = 0; g < ng; g++) begin
          dv = 1'b0;
          din = 1'($urandom_range(0, 1));
          @(negedge clk);
          check_int("gap_no_output", int'(out_valid), 0);
        end
      end
      dv = 1'b1;
      din = img[i];
      if (i == N / 2) thr = t1;
      @(negedge clk);
    end
    dv = 1'b0;
    if (npix == N) begin
      frames++;
      lo = 0;
      while (!in_ready && lo < 50) begin
        lo++;
        @(negedge clk);
      end
      // W+1 FLUSH cycles plus the single DONE cycle.
      check_int("in_ready_low_cycles", lo, W + 2);
    end
  endtask

  initial begin
    logic [N-1:0] ones, zeros, single, rnd;
    int n;
    ones = '1;
    zeros = '0;
    single = '0;
    single[1 * W + 3] = 1'b1;

    repeat (3) @(negedge clk);
    check_int("reset_in_ready", int'(in_ready), 1);
    check_int("reset_out_valid", int'(out_valid), 0);
    check_int("reset_data_me", int'(data_me), 0);
    check_int("reset_frame_done", int'(frame_done), 0);
    rst = 1'b0;
    @(negedge clk);

    send_frame(ones, 2'd0, 4'd4, 4'd4, 1'b0, N);
    send_frame(single, 2'd2, 4'd0, 4'd0, 1'b0, N);
    send_frame(ones, 2'd1, 4'd0, 4'd0, 1'b0, N);
    rnd = N'($urandom);
    send_frame(rnd, 2'd3, 4'd0, 4'd0, 1'b1, N);
    send_frame(ones, 2'd0, 4'd4, 4'd8, 1'b0, N);
    send_frame(ones, 2'd0, 4'd8, 4'd4, 1'b0, N);
    send_frame(zeros, 2'd2, 4'd0, 4'd0, 1'b0, N);

    // Partial frame of 13 pixels, then a restart with a pixel presented alongside it.
    send_frame(ones, 2'd0, 4'd4, 4'd4, 1'b0, 13);
    vs = 1'b1;
    dv = 1'b1;
    din = 1'b1;
    @(negedge clk);
    vs = 1'b0;
    dv = 1'b0;
    check_int("vsync_suppress_out_valid", int'(out_valid), 0);
    check_int("vsync_in_ready", int'(in_ready), 1);
    repeat (20) @(negedge clk);
    check_int("queue_after_vsync", exp_q.size(), 0);

    rnd = N'($urandom);
    send_frame(rnd, 2'd0, 4'd3, 4'd3, 1'b1, N);

    n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
    check_int("queue_drained", exp_q.size(), 0);
    check_int("frame_done_count", fd_count, frames);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
